// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: load/capture/unload sequencer for one mux-scan chain with response compare.
// Defining SCAN_CHAIN_CTRL_MISR_EN adds a signature output fed by a MISR over every unloaded bit.
module scan_chain_ctrl #(
   parameter int CHAIN_LEN = 16,
   parameter int NCAP_W    = 3
) (
   input  logic                 CLK,
   input  logic                 RN,
   input  logic                 start,
   input  logic [CHAIN_LEN-1:0] pattern,
   input  logic [CHAIN_LEN-1:0] expect_vec,
   input  logic [NCAP_W-1:0]    ncap,
   input  logic                 SO,
   output logic                 SE,
   output logic                 SI,
   output logic                 busy,
   output logic                 done,
   output logic [CHAIN_LEN-1:0] response,
   output logic                 mismatch
`ifdef SCAN_CHAIN_CTRL_MISR_EN
   ,
   output logic [CHAIN_LEN-1:0] signature
`endif
);
   localparam int CW = $clog2(CHAIN_LEN);
   localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

   typedef enum logic [2:0] {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, FINISH} state_t;

   state_t               r_state, w_state;
   logic [CW-1:0]        r_cnt, w_cnt;
   logic [NCAP_W-1:0]    r_cap, w_cap, r_ncap, w_ncap;
   logic [CHAIN_LEN-1:0] r_pat, w_pat, r_exp, w_exp, r_shadow, w_shadow, r_resp, w_resp;
   logic                 r_se, w_se, r_si, w_si, r_busy, w_busy, r_done, w_done, r_mis, w_mis;

   always_comb begin
      w_state  = r_state;
      w_cnt    = r_cnt;
      w_cap    = r_cap;
      w_ncap   = r_ncap;
      w_pat    = r_pat;
      w_exp    = r_exp;
      w_shadow = r_shadow;
      w_resp   = r_resp;
      w_mis    = r_mis;
      w_se     = r_se;
      w_si     = r_si;
      w_busy   = r_busy;
      w_done   = 1'b0;
      case (r_state)
         IDLE: if (start) begin
            w_state = SHIFT_IN;
            w_pat   = pattern;
            w_exp   = expect_vec;
            w_ncap  = ncap;
            w_cnt   = '0;
            w_se    = 1'b1;
            w_si    = pattern[0];
            w_busy  = 1'b1;
         end
         SHIFT_IN: if (r_cnt == LAST) begin
            w_state = (r_ncap != '0) ? CAPTURE : SHIFT_OUT;
            w_se    = (r_ncap == '0);
            w_si    = 1'b0;
            w_cnt   = '0;
            w_cap   = '0;
         end else begin
            w_cnt = r_cnt + 1'b1;
            w_si  = r_pat[w_cnt];
         end
         CAPTURE: if (r_cap == r_ncap - 1'b1) begin
            w_state = SHIFT_OUT;
            w_se    = 1'b1;
         end else
            w_cap = r_cap + 1'b1;
         // The sample taken at the edge leaving SHIFT_OUT is folded straight into the published response.
         SHIFT_OUT: begin
            w_shadow[r_cnt] = SO;
            if (r_cnt == LAST) begin
               w_state = FINISH;
               w_se    = 1'b0;
               w_busy  = 1'b0;
               w_done  = 1'b1;
               w_resp  = w_shadow;
               w_mis   = (w_shadow != r_exp);
            end else
               w_cnt = r_cnt + 1'b1;
         end
         FINISH:  w_state = IDLE;
         default: w_state = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RN)
      if (!RN) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_cap    <= '0;
         r_ncap   <= '0;
         r_pat    <= '0;
         r_exp    <= '0;
         r_shadow <= '0;
         r_resp   <= '0;
         r_mis    <= 1'b0;
         r_se     <= 1'b0;
         r_si     <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_cnt    <= w_cnt;
         r_cap    <= w_cap;
         r_ncap   <= w_ncap;
         r_pat    <= w_pat;
         r_exp    <= w_exp;
         r_shadow <= w_shadow;
         r_resp   <= w_resp;
         r_mis    <= w_mis;
         r_se     <= w_se;
         r_si     <= w_si;
         r_busy   <= w_busy;
         r_done   <= w_done;
      end

   assign SE       = r_se;
   assign SI       = r_si;
   assign busy     = r_busy;
   assign done     = r_done;
   assign response = r_resp;
   assign mismatch = r_mis;

`ifdef SCAN_CHAIN_CTRL_MISR_EN
   localparam logic [CHAIN_LEN-1:0] POLY = CHAIN_LEN'(1) | (CHAIN_LEN'(1) << (CHAIN_LEN - 1)) | CHAIN_LEN'(2);

   logic [CHAIN_LEN-1:0] r_misr, w_misr, r_sig;

   // Running MISR persists across patterns; the output copy only moves when done rises.
   assign w_misr = (r_state == SHIFT_OUT)
                 ? ({r_misr[CHAIN_LEN-2:0], 1'b0} ^ (r_misr[CHAIN_LEN-1] ? POLY : '0) ^ CHAIN_LEN'(SO))
                 : r_misr;

   always_ff @(posedge CLK or negedge RN)
      if (!RN) begin
         r_misr <= '0;
         r_sig  <= '0;
      end else begin
         r_misr <= w_misr;
         if (w_done) r_sig <= w_misr;
      end

   assign signature = r_sig;
`endif
endmodule
